hnoc_leaf_router: RTL
=====================

# hnoc_leaf_router

Parametrised single-clock leaf router for the hierarchical NoC. It replaces the fixed three-switch leaf with one N-leaf crossbar plus one uplink toward the next tree level. Each port has an input FIFO and a registered output stage. Routing uses an address-range decode of the destination field. Each output has a round-robin arbiter. Flits whose destination cannot be reached are dropped and counted.

## Interface
Parameters:
- DataWidth, 32, flit width in bits
- NumLeaf, 4, number of leaf (PE-side) ports, 2..8
- AddrWidth, 4, destination field width; field is flit bits [DataWidth-1 -: AddrWidth]
- LocalMin, 0, lowest destination address served by this leaf
- LocalMax, 3, highest local address; LocalMax-LocalMin+1 must equal NumLeaf
- FifoDepth, 4, entries per input FIFO, power of two, >= 2

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset  in  1  reset; synchronous, active-low
- i_leaf_data  in  NumLeaf*DataWidth  flits from leaves; port k at [k*DataWidth +: DataWidth]
- i_leaf_data_valid  in  NumLeaf  per-leaf input valid
- o_leaf_data_ready  out  NumLeaf  per-leaf input ready
- o_leaf_data  out  NumLeaf*DataWidth  flits to leaves
- o_leaf_data_valid  out  NumLeaf  per-leaf output valid
- i_leaf_data_ready  in  NumLeaf  per-leaf downstream ready
- i_up_data / i_up_data_valid / o_up_data_ready  in/in/out  DataWidth/1/1  uplink input channel
- o_up_data / o_up_data_valid / i_up_data_ready  out/out/in  DataWidth/1/1  uplink output channel
- o_drop_count  out  16  saturating count of dropped flits

## Operation
- Port indexing: inputs and outputs 0..NumLeaf-1 are leaves. Index NumLeaf is the uplink.
- Transfer occurs on a rising edge where valid and ready are both high. Valid must not depend on ready.
- Input FIFO per port. A flit is written on transfer. The FIFO head drives that port's request.
- Route decode of the head flit, with dest = head[DataWidth-1 -: AddrWidth]:
  - LocalMin <= dest <= LocalMax: request leaf output dest-LocalMin. A leaf may address itself (loopback is legal).
  - Otherwise, from a leaf input: request the uplink output.
  - Otherwise, from the uplink input: the flit is a misroute. It is popped that cycle with no output. o_drop_count increments and saturates at 16'hFFFF.
- Per-output round-robin arbiter over the NumLeaf+1 inputs requesting it:
  - Priority order starts at pointer p.
  - After a grant to input g, p becomes (g+1) mod (NumLeaf+1).
  - p is unchanged when there is no grant.
- An output register is loadable when o_valid is 0, or when o_valid and i_ready are both 1 in the same cycle (full throughput).
- Grant is issued only if the target output register is loadable. The granted FIFO pops, and the register takes the head flit unmodified.
- Each input requests exactly one output, so at most one grant per input per cycle. Different outputs grant in parallel.
- Flits from one input to one output leave in arrival order. No ordering between different inputs.

## Timing
- Reset (i_reset low at an edge) takes effect at that edge, including mid-packet:
  - all FIFOs empty; in-flight and buffered flits are discarded
  - all o_*_valid = 0; o_*_data = 0
  - all arbiter pointers = 0
  - o_drop_count = 0
  - o_*_data_ready = 0 while reset is asserted
- First edge after reset release: o_*_data_ready = 1.
- o_*_data_ready = (FIFO count != FifoDepth), taken from the registered count.
  - It does not rise combinationally on a same-cycle pop. A full FIFO accepts again the cycle after a pop.
- Simultaneous push and pop leaves the count unchanged. This is legal at any count other than 0 and FifoDepth.
- Latency: a flit accepted at edge t with an idle path is in the output register at edge t+1. o_valid is high in the cycle after t+1.
- Throughput: 1 flit/cycle per output with continuous downstream ready.
- Drop: a misrouted uplink head pops at the edge after it reaches the head. o_drop_count updates at the same edge.
- Output hold: o_data and o_valid stay stable while o_valid=1 and i_ready=0.

## Test plan
- Reset and single flit:
  - Release reset. Leaf 2 sends 32'h1000_00AA with all downstream ready.
  - Required: o_leaf_data_ready = 4'hF one cycle after release. Output 1 shows valid with 32'h1000_00AA one cycle after acceptance. Other outputs stay 0.
- Uplink route and drop:
  - Leaf 0 sends dest 4'h9: it appears on o_up_data.
  - Uplink sends dest 4'h9 three times: no output valid; o_drop_count = 3.
- Round-robin contention:
  - Leaves 0, 1, 3 and the uplink each stream flits to leaf 2 with ready held high.
  - Required grant order: 0, 1, 3, up, 0, 1, ...; exactly 1 flit/cycle on output 2.
- Backpressure and full:
  - Hold i_leaf_data_ready[3] = 0 while leaf 0 sends 6 flits to dest 3.
  - Required: the output register holds the first flit and the FIFO takes 4 more, so o_leaf_data_ready[0] = 0 after 5 accepts.
  - Release ready: all 6 flits delivered in order. Ready returns one cycle after the first pop.
- Reset mid-operation:
  - Assert i_reset during the full-FIFO scenario.
  - Required: all valids 0, o_drop_count = 0, no stale flit delivered after release.
- Parallel paths and saturation:
  - Leaf 0 -> 1 and leaf 1 -> 0 simultaneously for 100 cycles: both outputs carry 1 flit/cycle.
  - Force 65540 drops: o_drop_count = 16'hFFFF.

Source files
------------

// File: rtl/hnoc_leaf_router_if.sv
// Handshake bundle for the leaf router: NumLeaf leaf channels plus one uplink channel,
// each with an input (toward the router) and an output (from the router) direction.
interface hnoc_leaf_router_if #(
    parameter int DataWidth = 32,
    parameter int NumLeaf   = 4
) ();
    logic [NumLeaf*DataWidth-1:0] i_leaf_data;
    logic [NumLeaf-1:0]           i_leaf_data_valid;
    logic [NumLeaf-1:0]           o_leaf_data_ready;
    logic [NumLeaf*DataWidth-1:0] o_leaf_data;
    logic [NumLeaf-1:0]           o_leaf_data_valid;
    logic [NumLeaf-1:0]           i_leaf_data_ready;
    logic [DataWidth-1:0]         i_up_data;
    logic                         i_up_data_valid;
    logic                         o_up_data_ready;
    logic [DataWidth-1:0]         o_up_data;
    logic                         o_up_data_valid;
    logic                         i_up_data_ready;

    // Router side
    modport slave (
        input  i_leaf_data, i_leaf_data_valid, i_leaf_data_ready,
        input  i_up_data, i_up_data_valid, i_up_data_ready,
        output o_leaf_data_ready, o_leaf_data, o_leaf_data_valid,
        output o_up_data_ready, o_up_data, o_up_data_valid
    );

    // Environment side (leaves and next tree level)
    modport master (
        output i_leaf_data, i_leaf_data_valid, i_leaf_data_ready,
        output i_up_data, i_up_data_valid, i_up_data_ready,
        input  o_leaf_data_ready, o_leaf_data, o_leaf_data_valid,
        input  o_up_data_ready, o_up_data, o_up_data_valid
    );
endinterface

// File: rtl/hnoc_leaf_router.sv
// Leaf router: NumLeaf leaf ports plus an uplink (port index NumLeaf). Each input has a FIFO,
// each output a registered stage with round-robin arbitration. Uplink flits with a non-local
// destination are dropped and counted.
module hnoc_leaf_router #(
    parameter int DataWidth = 32,
    parameter int NumLeaf   = 4,
    parameter int AddrWidth = 4,
    parameter int LocalMin  = 0,
    parameter int LocalMax  = 3,
    parameter int FifoDepth = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hnoc_leaf_router_if.slave bus,
    output logic [15:0]       o_drop_count
);
    localparam int NumPort = NumLeaf + 1;
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int CntW    = PtrW + 1;
    localparam int TgtW    = $clog2(NumPort);

    typedef logic [DataWidth-1:0] flit_t;

    flit_t              in_data [NumPort];
    logic [NumPort-1:0] in_valid;
    logic [NumPort-1:0] in_ready;
    logic [NumPort-1:0] out_ready;

    flit_t           mem_q    [NumPort][FifoDepth];
    flit_t           mem_d    [NumPort][FifoDepth];
    logic [PtrW-1:0] wr_ptr_q [NumPort];
    logic [PtrW-1:0] wr_ptr_d [NumPort];
    logic [PtrW-1:0] rd_ptr_q [NumPort];
    logic [PtrW-1:0] rd_ptr_d [NumPort];
    logic [CntW-1:0] cnt_q    [NumPort];
    logic [CntW-1:0] cnt_d    [NumPort];
    logic            run_q;

    flit_t              head    [NumPort];
    logic [NumPort-1:0] push;
    logic [NumPort-1:0] pop;
    logic [NumPort-1:0] req;
    logic [NumPort-1:0] drop;
    logic [NumPort-1:0] gnt;
    logic [TgtW-1:0]    req_tgt [NumPort];

    logic [TgtW-1:0]    rr_ptr_q [NumPort];
    logic [TgtW-1:0]    rr_ptr_d [NumPort];
    logic [NumPort-1:0] src_vld;
    logic [TgtW-1:0]    src_idx  [NumPort];
    logic [NumPort-1:0] oval_q;
    logic [NumPort-1:0] oval_d;
    flit_t              odata_q  [NumPort];
    flit_t              odata_d  [NumPort];
    logic [15:0]        drop_cnt_q;
    logic [15:0]        drop_cnt_d;

    // Flatten the interface into per-port arrays indexed 0..NumLeaf
    always_comb begin
        in_data = '{default: '0};
        for (int k = 0; k < NumLeaf; k++) begin
            in_data[k] = bus.i_leaf_data[k*DataWidth +: DataWidth];
        end
        in_data[NumLeaf] = bus.i_up_data;
        in_valid  = {bus.i_up_data_valid, bus.i_leaf_data_valid};
        out_ready = {bus.i_up_data_ready, bus.i_leaf_data_ready};
    end

    // Drive the interface outputs straight from registered state
    always_comb begin
        bus.o_leaf_data = '0;
        for (int k = 0; k < NumLeaf; k++) begin
            bus.o_leaf_data[k*DataWidth +: DataWidth] = odata_q[k];
        end
        bus.o_leaf_data_valid = oval_q[NumLeaf-1:0];
        bus.o_up_data         = odata_q[NumLeaf];
        bus.o_up_data_valid   = oval_q[NumLeaf];
        bus.o_leaf_data_ready = in_ready[NumLeaf-1:0];
        bus.o_up_data_ready   = in_ready[NumLeaf];
    end

    assign o_drop_count = drop_cnt_q;

    // FIFO status and route decode of each head flit
    always_comb begin
        logic [AddrWidth-1:0] dest;
        int                   dest_i;
        logic                 is_local;
        dest     = '0;
        dest_i   = 0;
        is_local = 1'b0;
        in_ready = '0;
        push     = '0;
        req      = '0;
        drop     = '0;
        head     = '{default: '0};
        req_tgt  = '{default: '0};
        for (int i = 0; i < NumPort; i++) begin
            // Ready comes from the registered count only; a same-cycle pop does not raise it.
            in_ready[i] = run_q && (cnt_q[i] != CntW'(FifoDepth));
            push[i]     = in_valid[i] && in_ready[i];
            head[i]     = mem_q[i][rd_ptr_q[i]];
            dest        = head[i][DataWidth-1 -: AddrWidth];
            dest_i      = int'(dest);
            is_local    = (dest_i >= LocalMin) && (dest_i <= LocalMax);
            req_tgt[i]  = is_local ? TgtW'(dest_i - LocalMin) : TgtW'(NumLeaf);
            req[i]      = (cnt_q[i] != '0) && (is_local || (i < NumLeaf));
            // Non-local destination arriving from above has nowhere to go.
            drop[i]     = (cnt_q[i] != '0) && !is_local && (i == NumLeaf);
        end
    end

    // Per-output round-robin arbitration, only when the output register can load
    always_comb begin
        int idx;
        idx      = 0;
        gnt      = '0;
        src_vld  = '0;
        src_idx  = '{default: '0};
        rr_ptr_d = rr_ptr_q;
        for (int o = 0; o < NumPort; o++) begin
            if (!oval_q[o] || out_ready[o]) begin
                for (int k = 0; k < NumPort; k++) begin
                    idx = (int'(rr_ptr_q[o]) + k) % NumPort;
                    if (!src_vld[o] && req[idx] && (int'(req_tgt[idx]) == o)) begin
                        src_vld[o] = 1'b1;
                        src_idx[o] = TgtW'(idx);
                    end
                end
            end
            if (src_vld[o]) begin
                gnt[src_idx[o]] = 1'b1;
                rr_ptr_d[o] = (int'(src_idx[o]) == NumPort - 1) ? '0 : src_idx[o] + TgtW'(1);
            end
        end
    end

    // FIFO pointers/contents, output registers and drop counter next state
    always_comb begin
        pop   = gnt | drop;
        mem_d = mem_q;
        for (int i = 0; i < NumPort; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
            cnt_d[i]    = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data[i];
            end
        end
        oval_d  = oval_q;
        odata_d = odata_q;
        for (int o = 0; o < NumPort; o++) begin
            if (src_vld[o]) begin
                oval_d[o]  = 1'b1;
                odata_d[o] = head[src_idx[o]];
            end else if (out_ready[o]) begin
                oval_d[o] = 1'b0;
            end
        end
        drop_cnt_d = drop_cnt_q;
        if (drop[NumLeaf] && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // FIFO storage; contents need no reset because the pointers are cleared
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            run_q      <= 1'b0;
            oval_q     <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NumPort; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                rr_ptr_q[i] <= '0;
                odata_q[i]  <= '0;
            end
        end else begin
            run_q      <= 1'b1;
            oval_q     <= oval_d;
            drop_cnt_q <= drop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            odata_q    <= odata_d;
        end
    end
endmodule
